branch_controller: RTL and testbench

Sequencer that owns the program counter and executes jump requests from the decode stage. Accepts one jump request at a time (unconditional, jump-if-less-than, jump-if-greater-than), evaluates the comparison, redirects the PC by a signed offset when taken, and holds a fetch flush for a fixed number of cycles afterwards. Sits between decode and the fetch path and replaces ad-hoc per-jump PC updates with a single arbitrated owner.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_compare.sv | 24 ++
 rtl/branch_controller.sv | 124 ++++++++++++
 tb/tb_branch_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: request kinds, FSM states and
// the width of the post-jump flush counter.
package branch_pkg;

  localparam logic [1:0] KIND_JMP  = 2'b00;
  localparam logic [1:0] KIND_JLT  = 2'b01;
  localparam logic [1:0] KIND_JGT  = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EVAL  = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Wide enough for the largest legal flush length of 15 cycles.
  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_compare.sv
// Combinational jump decision: signed compare of two operands qualified by the
// request kind. Shared by any unit that needs a conditional take decision.
module branch_compare
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]              kind_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic                    take_o
);

  always_comb begin
    take_o = 1'b0;
    case (kind_i)
      KIND_JMP:  take_o = 1'b1;
      KIND_JLT:  take_o = (a_i < b_i);
      KIND_JGT:  take_o = (a_i > b_i);
      default:   take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_controller.sv
// Program-counter owner: sequential fetch advance plus one-at-a-time jump
// requests, with a fixed-length fetch flush after every taken jump.
module branch_controller
  import branch_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             flush,
  output logic             done,
  output logic             taken
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                   state_q;
  logic [WIDTH-1:0]         pc_q;
  logic                     flush_q;
  logic                     done_q;
  logic                     taken_q;
  logic [FLUSH_CNT_W-1:0]   cnt_q;

  logic [1:0]               kind_q;
  logic signed [WIDTH-1:0]  a_q;
  logic signed [WIDTH-1:0]  b_q;
  logic signed [WIDTH-1:0]  off_q;

  logic                     take;
  logic                     accept;
  logic [WIDTH-1:0]         pc_inc_d;
  logic [WIDTH-1:0]         pc_tgt_d;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = (state_q == ST_IDLE) && req_valid;

  // Both adders wrap silently modulo 2^WIDTH.
  assign pc_inc_d = pc_q + WIDTH'(1);
  assign pc_tgt_d = pc_q + $unsigned(off_q);

  branch_compare #(
    .WIDTH (WIDTH)
  ) u_compare (
    .kind_i (kind_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .take_o (take)
  );

  // Request payload is only meaningful after acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_q <= req_kind;
      a_q    <= $signed(cmp_a);
      b_q    <= $signed(cmp_b);
      off_q  <= $signed(offset);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q <= ST_EVAL;
          end else if (advance) begin
            pc_q <= pc_inc_d;
          end
        end
        ST_EVAL: begin
          done_q  <= 1'b1;
          taken_q <= take;
          if (take) begin
            pc_q    <= pc_tgt_d;
            flush_q <= 1'b1;
            cnt_q   <= FLUSH_LAST;
            state_q <= ST_FLUSH;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // cnt_q counts remaining flush cycles after the current one.
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          flush_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc    = pc_q;
  assign flush = flush_q;
  assign done  = done_q;
  assign taken = taken_q;

endmodule

// File: tb/tb_branch_controller.sv
// Self-checking bench for branch_controller: directed scenarios plus
// randomized jump traffic against a behavioural PC model.
module tb_branch_controller;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         advance = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_kind = 2'b00;
  logic [W-1:0] cmp_a = '0;
  logic [W-1:0] cmp_b = '0;
  logic [W-1:0] offset = '0;
  logic [W-1:0] pc;
  logic         flush;
  logic         done;
  logic         taken;

  int checks = 0;
  int failures = 0;

  branch_controller #(
    .WIDTH        (W),
    .RESET_PC     (16'h0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .offset    (offset),
    .pc        (pc),
    .flush     (flush),
    .done      (done),
    .taken     (taken)
  );

  always #5 clk = ~clk;

  function automatic int to_int(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic bit model_take(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b);
    case (k)
      2'd0:    return 1'b1;
      2'd1:    return to_int(a) < to_int(b);
      2'd2:    return to_int(a) > to_int(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_n(input int n);
    advance = 1'b1;
    repeat (n) step();
    advance = 1'b0;
  endtask

  // Drives one request from IDLE and records what the DUT showed until ready returns.
  task automatic txn(input logic [1:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] off, input bit noise,
                     output logic rdy_acc, output logic [W-1:0] pc_eval, output logic [W-1:0] pc_done,
                     output int n_done, output logic tk, output int n_flush, output int n_rlow,
                     output bit timeout);
    rdy_acc   = req_ready;
    req_valid = 1'b1;
    req_kind  = k;
    cmp_a     = a;
    cmp_b     = b;
    offset    = off;
    advance   = noise ? 1'($urandom % 2) : 1'b0;
    step();
    req_valid = 1'b0;
    cmp_a     = W'($urandom);
    cmp_b     = W'($urandom);
    offset    = W'($urandom);
    pc_eval = pc;
    n_done  = done ? 1 : 0;
    n_flush = flush ? 1 : 0;
    n_rlow  = req_ready ? 0 : 1;
    tk      = 1'b0;
    pc_done = 'x;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      advance = noise ? 1'($urandom % 2) : 1'b0;
      step();
      if (done) begin n_done++; tk = taken; pc_done = pc; end
      if (flush) n_flush++;
      if (req_ready) begin timeout = 1'b0; break; end
      n_rlow++;
    end
    advance = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%h exp=0000", pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
    checks++; if (done !== 1'b0 || taken !== 1'b0) begin failures++; $display("FAIL rst_done_taken got=%b%b exp=00", done, taken); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_in_reset got=%b exp=0", req_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_advance();
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (done !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL adv_quiet got=%b%b exp=00", done, flush); end
    end
    advance = 1'b0;
    checks++; if (pc !== 16'h0003) begin failures++; $display("FAIL adv_pc got=%h exp=0003", pc); end
  endtask

  task automatic test_jmp();
    logic r, tk; logic [W-1:0] pe, pd; int nd, nf, nr; bit to;
    txn(2'b00, 16'h1234, 16'h0000, 16'h0010, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL jmp_ready_acc got=%b exp=1", r); end
    checks++; if (pe !== 16'h0003) begin failures++; $display("FAIL jmp_pc_hold got=%h exp=0003", pe); end
    checks++; if (pd !== 16'h0013) begin failures++; $display("FAIL jmp_pc got=%h exp=0013", pd); end
    checks++; if (nd != 1 || tk !== 1'b1) begin failures++; $display("FAIL jmp_done_taken got=%0d/%b exp=1/1", nd, tk); end
    checks++; if (nf != 2) begin failures++; $display("FAIL jmp_flush_cycles got=%0d exp=2", nf); end
    checks++; if (nr != 3 || to) begin failures++; $display("FAIL jmp_ready_low got=%0d timeout=%0d exp=3", nr, to); end
  endtask

  task automatic test_jlt();
    logic r, tk; logic [W-1:0] pe, pd; int nd, nf, nr; bit to;
    advance_n(13);
    checks++; if (pc !== 16'h0020) begin failures++; $display("FAIL jlt_start_pc got=%h exp=0020", pc); end
    txn(2'b01, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (pd !== 16'h001E || tk !== 1'b1) begin failures++; $display("FAIL jlt_signed got=%h/%b exp=001e/1", pd, tk); end
    checks++; if (nf != 2 || nd != 1) begin failures++; $display("FAIL jlt_flush_done got=%0d/%0d exp=2/1", nf, nd); end
  endtask

  task automatic test_jgt_equal();
    logic r, tk; logic [W-1:0] pe, pd; int nd, nf, nr; bit to;
    advance_n(34);
    checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL jgt_start_pc got=%h exp=0040", pc); end
    txn(2'b10, 16'h0005, 16'h0005, 16'h1234, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (pd !== 16'h0041 || tk !== 1'b0 || nd != 1) begin failures++; $display("FAIL jgt_equal got=%h/%b/%0d exp=0041/0/1", pd, tk, nd); end
    checks++; if (nf != 0 || nr != 1) begin failures++; $display("FAIL jgt_no_flush got=%0d/%0d exp=0/1", nf, nr); end
    txn(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (r !== 1'b1 || pd !== 16'h0041 || tk !== 1'b1) begin failures++; $display("FAIL back_to_back got=%b/%h/%b exp=1/0041/1", r, pd, tk); end
  endtask

  task automatic test_wrap();
    logic r, tk; logic [W-1:0] pe, pd; int nd, nf, nr; bit to;
    txn(2'b00, 16'h0, 16'h0, 16'hFFBE, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (pd !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup got=%h exp=ffff", pd); end
    txn(2'b00, 16'h0, 16'h0, 16'h0002, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (pd !== 16'h0001) begin failures++; $display("FAIL wrap_pc got=%h exp=0001", pd); end
    txn(2'b00, 16'h0, 16'h0, 16'h00FF, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    txn(2'b11, 16'h0000, 16'h0001, 16'h0050, 1'b0, r, pe, pd, nd, tk, nf, nr, to);
    checks++; if (pd !== 16'h0101 || tk !== 1'b0 || nf != 0) begin failures++; $display("FAIL rsvd_kind got=%h/%b/%0d exp=0101/0/0", pd, tk, nf); end
  endtask

  task automatic test_hold_and_reset();
    req_valid = 1'b1; req_kind = 2'b00; offset = 16'h0004;
    step();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_eval_ready got=%b exp=0", req_ready); end
    step();
    checks++; if (pc !== 16'h0105 || done !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL hold_first got=%h/%b/%b exp=0105/1/1", pc, done, flush); end
    step();
    checks++; if (req_ready !== 1'b0 || done !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL hold_flush2 got=%b/%b/%b exp=0/0/1", req_ready, done, flush); end
    step();
    checks++; if (req_ready !== 1'b1 || flush !== 1'b0 || pc !== 16'h0105) begin failures++; $display("FAIL hold_idle got=%b/%b/%h exp=1/0/0105", req_ready, flush, pc); end
    step();
    checks++; if (req_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL hold_reaccept got=%b/%b exp=0/0", req_ready, done); end
    step();
    checks++; if (pc !== 16'h0109 || done !== 1'b1) begin failures++; $display("FAIL hold_second got=%h/%b exp=0109/1", pc, done); end
    step();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL midflush_pre got=%b exp=1", flush); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000 || flush !== 1'b0) begin failures++; $display("FAIL midflush_async got=%h/%b exp=0000/0", pc, flush); end
    checks++; if (done !== 1'b0 || taken !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL midflush_outs got=%b/%b/%b exp=0/0/0", done, taken, req_ready); end
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midflush_ready got=%b exp=1", req_ready); end
    step();
    checks++; if (done !== 1'b0 || pc !== 16'h0000 || flush !== 1'b0) begin failures++; $display("FAIL midflush_after got=%b/%h/%b exp=0/0000/0", done, pc, flush); end
  endtask

  task automatic test_random();
    logic r, tk; logic [W-1:0] pe, pd; int nd, nf, nr; bit to;
    logic [1:0] k; logic [W-1:0] a, b, off;
    int mpc; bit exp_tk; int exp_pc;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    mpc = 0;
    for (int t = 0; t < 150; t++) begin
      for (int g = 0; g < int'($urandom % 4); g++) begin
        advance = 1'($urandom % 2);
        if (advance) mpc = (mpc + 1) % 65536;
        step();
      end
      advance = 1'b0;
      k   = 2'($urandom);
      a   = W'($urandom);
      b   = ($urandom % 4 == 0) ? a : W'($urandom);
      off = W'($urandom);
      exp_tk = model_take(k, a, b);
      exp_pc = exp_tk ? (mpc + int'(off)) % 65536 : (mpc + 1) % 65536;
      txn(k, a, b, off, 1'b1, r, pe, pd, nd, tk, nf, nr, to);
      checks++; if (r !== 1'b1 || pe !== W'(mpc)) begin failures++; $display("FAIL rnd_accept t=%0d got=%b/%h exp=1/%h", t, r, pe, W'(mpc)); end
      checks++; if (nd != 1 || tk !== exp_tk) begin failures++; $display("FAIL rnd_taken t=%0d k=%0d a=%h b=%h got=%0d/%b exp=1/%b", t, k, a, b, nd, tk, exp_tk); end
      checks++; if (pd !== W'(exp_pc)) begin failures++; $display("FAIL rnd_pc t=%0d got=%h exp=%h", t, pd, W'(exp_pc)); end
      checks++; if (nf != (exp_tk ? 2 : 0) || nr != (exp_tk ? 3 : 1) || to) begin failures++; $display("FAIL rnd_timing t=%0d got=%0d/%0d exp=%0d/%0d", t, nf, nr, exp_tk ? 2 : 0, exp_tk ? 3 : 1); end
      mpc = exp_pc;
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_jmp();
    test_jlt();
    test_jgt_equal();
    test_wrap();
    test_hold_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
